ysyx_23060061_ifu_prefetch: RTL and testbench
=============================================

# ysyx_23060061_ifu_prefetch

Parametrised instruction-fetch unit with a prefetch queue. It sits between the PC/redirect logic and the IDU, and drives the AXI4-Lite read channel towards instruction memory. It fetches sequentially ahead of the IDU into a `FIFO_DEPTH`-entry queue, squashes queued and in-flight fetches on redirect, and tags bus errors and misaligned targets as faults.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: first fetch address after reset.
- `FIFO_DEPTH`, default 4: instruction queue entries. Power of two, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `redirect_valid` in 1: non-sequential PC change (branch/jump/trap). Single-cycle pulse.
- `redirect_pc` in 32: new fetch target, sampled when `redirect_valid`=1.
- `inst_valid` out 1: queue head valid.
- `inst` out 32: head instruction word.
- `inst_pc` out 32: head PC.
- `inst_fault` out 1: head is an access/misalign fault; `inst`=0.
- `iduReady` in 1: IDU accepts head when `inst_valid & iduReady`.
- `araddr` out 32, `arvalid` out 1, `arready` in 1: AXI4-Lite AR channel.
- `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1: AXI4-Lite R channel.
- No write channel; the block never writes.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - `state` ∈ {IDLE, SEND_ADDR, WAIT_DATA}.
  - `drop`: discard pending response.
  - `halted`: stop fetching after a fault.
  - Queue of {pc, inst, fault} entries.
  - `inflight`: 0/1, set from AR accept until R handshake.
- Issue condition: `count + inflight < FIFO_DEPTH`, `!halted`, and no redirect this cycle.
- Overflow is impossible: every accepted AR has a reserved queue slot.
- IDLE:
  - If issue is allowed: `araddr<=fetch_pc`, `arvalid<=1`, go SEND_ADDR.
- SEND_ADDR:
  - Hold `arvalid` and `araddr` stable until `arready`.
  - On handshake: `arvalid<=0`, `rready<=1`, `fetch_pc+=4`, go WAIT_DATA.
- WAIT_DATA, on `rvalid & rready`:
  - If `!drop`, push {araddr, rdata, rresp!=0}.
  - If `rresp`!=0, push `inst`=0 and set `halted`.
  - Clear `drop`. `rready<=0`.
  - If issue is allowed, go straight to SEND_ADDR with the next PC. Otherwise go IDLE.
- Redirect (highest priority):
  - Flush the queue: `count` becomes 0; a same-cycle pop is ignored.
  - `fetch_pc<=redirect_pc`. Clear `halted`.
  - In IDLE: go SEND_ADDR with `araddr<=redirect_pc`.
  - In SEND_ADDR: an AR already asserted cannot be withdrawn. Complete it and set `drop`.
  - In WAIT_DATA without `rvalid`: set `drop`.
  - In WAIT_DATA with same-cycle `rvalid`: discard the response, go SEND_ADDR with `redirect_pc`, leave `drop`=0.
- Misaligned target (`redirect_pc[1:0]`!=0):
  - No bus access.
  - Once the queue is free, push {redirect_pc, 0, fault=1} and set `halted`.
- Queue pop: on `inst_valid & iduReady`. Push and pop may occur in the same cycle; `count` is unchanged.
- PC arithmetic: 32-bit wrap-around. 32'hFFFF_FFFC+4 = 0, no flag.

## Timing
- Reset values (asynchronous):
  - `arvalid`=0, `rready`=0, `inst_valid`=0, `araddr`=`RESET_PC`.
  - `fetch_pc`=`RESET_PC`, `state`=IDLE, `drop`=0, `halted`=0, queue empty.
- First `arvalid` appears in the 2nd cycle after `rst` deasserts.
- Reset mid-transaction: all state is abandoned immediately. The slave is reset by the same `rst`.
- Outputs `inst`/`inst_pc`/`inst_fault`/`inst_valid` come straight from queue head registers; no combinational path from `iduReady`.
- Latency with a zero-wait slave (redirect sampled at cycle 0):
  - `arvalid` at cycle 1, with `arready` in cycle 1.
  - `rready`/`rvalid` at cycle 2.
  - `inst_valid` at cycle 3.
- Steady-state throughput: 1 instruction per 2 cycles when the slave is zero-wait and the queue is not full.
- `rready` is high only in WAIT_DATA. `arvalid` is never high at the same time as `rready`.

## Structure
- Shared package `ysyx_23060061_pkg`:
  - `ifu_state_t` enum.
  - `AXI_RESP_OKAY`=2'b00.
  - Fetch-entry struct {pc, inst, fault}.
- Sub-module `ysyx_23060061_ifu_fifo`:
  - Synchronous FIFO of entry structs, parametrised by depth.
  - Ports: push, pop, flush, count, head.
  - Flush overrides push and pop.
- Top level holds the FSM, `fetch_pc`, `drop`/`halted` flags, and the issue-credit logic.

## Test plan
- **Reset fetch:** zero-wait slave returning `addr^32'hA5A5_0000`, IDU always ready → `araddr` sequence 80000000, 80000004, 80000008. `inst_pc` matches, and `inst`=`araddr^A5A50000`.
- **Backpressure:** `iduReady`=0 for 20 cycles, `FIFO_DEPTH`=4 → exactly 4 AR handshakes and `arvalid` stays low. Raising `iduReady` resumes fetch at 80000010.
- **Squash:** redirect to 80000100 while in WAIT_DATA, then slave delivers `rvalid` 3 cycles later → that response is not queued. The next `araddr`=80000100 and the queue holds only PCs ≥80000100.
- **Redirect during SEND_ADDR** with `arready` low for 5 cycles → `araddr`/`arvalid` stay stable until accepted. The response is dropped, then 80000200 is fetched.
- **Bus error:** `rresp`=2'b10 at 80000008 → entry {80000008, 0, fault=1} is queued and no further AR is issued. Redirect to 80000000 resumes fetching.
- **Misaligned redirect** to 80000002 → no AR, entry {80000002, 0, fault=1} is queued, and the block halts.

Source files
------------

// File: rtl/ysyx_23060061_pkg.sv
// Shared types for the ysyx_23060061 instruction-fetch path: FSM states,
// AXI response codes and the prefetch queue entry.
package ysyx_23060061_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_ADDR = 2'd1,
    WAIT_DATA = 2'd2
  } ifu_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

  function automatic fetch_entry_t make_fault_entry(input logic [31:0] pc);
    make_fault_entry = '{pc: pc, inst: 32'h0, fault: 1'b1};
  endfunction

endpackage

// File: rtl/ysyx_23060061_ifu_prefetch_if.sv
// AXI4-Lite read-only channel between the IFU (master) and instruction memory (slave).
interface ysyx_23060061_ifu_prefetch_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/ysyx_23060061_ifu_fifo.sv
// Synchronous FIFO of fetch entries; flush empties it and overrides push/pop.
module ysyx_23060061_ifu_fifo
  import ysyx_23060061_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !flush && (count != '0);
  assign do_push = push && !flush && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_23060061_ifu_prefetch.sv
// Instruction-fetch unit: prefetches sequential words over AXI4-Lite into a
// queue, squashes on redirect and reports bus errors / misaligned targets as faults.
module ysyx_23060061_ifu_prefetch
  import ysyx_23060061_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                redirect_valid,
  input  logic [31:0]                         redirect_pc,
  output logic                                inst_valid,
  output logic [31:0]                         inst,
  output logic [31:0]                         inst_pc,
  output logic                                inst_fault,
  input  logic                                iduReady,
  ysyx_23060061_ifu_prefetch_if.master        axi
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  ifu_state_t    state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [31:0]   araddr, araddr_n;
  logic [31:0]   mis_pc, mis_pc_n;
  logic          arvalid, arvalid_n;
  logic          rready, rready_n;
  logic          drop, drop_n;
  logic          halted, halted_n;
  logic          mis_pending, mis_pending_n;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          push;
  logic          pop;

  logic          ar_fire;
  logic          r_fire;
  logic          resp_err;
  logic          aligned;
  logic          inflight;
  logic          can_issue;
  logic [CW:0]   used;

  assign ar_fire  = arvalid && axi.arready;
  assign r_fire   = rready && axi.rvalid;
  assign resp_err = axi.rresp != AXI_RESP_OKAY;
  assign aligned  = redirect_pc[1:0] == 2'b00;
  assign inflight = state == WAIT_DATA;

  // Counting the in-flight beat reserves its queue slot, so a push can never overflow.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign can_issue = (used < DEPTH_W) && !halted && !mis_pending && !redirect_valid;

  assign inst_valid = count != '0;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign inst_fault = head.fault;
  assign pop        = inst_valid && iduReady;

  assign axi.araddr  = araddr;
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;

  ysyx_23060061_ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      araddr      <= RESET_PC;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      drop        <= 1'b0;
      halted      <= 1'b0;
      mis_pending <= 1'b0;
      mis_pc      <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      araddr      <= araddr_n;
      arvalid     <= arvalid_n;
      rready      <= rready_n;
      drop        <= drop_n;
      halted      <= halted_n;
      mis_pending <= mis_pending_n;
      mis_pc      <= mis_pc_n;
    end
  end

  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    araddr_n      = araddr;
    arvalid_n     = arvalid;
    rready_n      = rready;
    drop_n        = drop;
    halted_n      = halted;
    mis_pending_n = mis_pending;
    mis_pc_n      = mis_pc;
    push          = 1'b0;
    push_entry    = '0;

    case (state)
      IDLE: begin
        if (can_issue) begin
          araddr_n  = fetch_pc;
          arvalid_n = 1'b1;
          state_n   = SEND_ADDR;
        end
      end
      SEND_ADDR: begin
        if (ar_fire) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          // A stale beat must not advance the PC past the redirect target.
          if (!drop) fetch_pc_n = fetch_pc + 32'd4;
          state_n = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (r_fire) begin
          rready_n = 1'b0;
          drop_n   = 1'b0;
          if (!drop) begin
            push       = 1'b1;
            push_entry = '{pc: araddr, inst: resp_err ? 32'h0 : axi.rdata, fault: resp_err};
            if (resp_err) halted_n = 1'b1;
          end
          if (can_issue && !(resp_err && !drop)) begin
            araddr_n  = fetch_pc;
            arvalid_n = 1'b1;
            state_n   = SEND_ADDR;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (mis_pending && !push && ({1'b0, count} < DEPTH_W)) begin
      push          = 1'b1;
      push_entry    = make_fault_entry(mis_pc);
      halted_n      = 1'b1;
      mis_pending_n = 1'b0;
    end

    // Redirect wins over everything above; the FIFO flush drops any push this cycle.
    if (redirect_valid) begin
      fetch_pc_n    = redirect_pc;
      halted_n      = 1'b0;
      mis_pending_n = !aligned;
      mis_pc_n      = redirect_pc;
      case (state)
        IDLE: begin
          if (aligned) begin
            araddr_n  = redirect_pc;
            arvalid_n = 1'b1;
            state_n   = SEND_ADDR;
          end
        end
        SEND_ADDR: drop_n = 1'b1;
        WAIT_DATA: begin
          if (r_fire) begin
            drop_n = 1'b0;
            if (aligned) begin
              araddr_n  = redirect_pc;
              arvalid_n = 1'b1;
              state_n   = SEND_ADDR;
            end else begin
              arvalid_n = 1'b0;
              state_n   = IDLE;
            end
          end else begin
            drop_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_ifu_prefetch.sv
// Directed bench for the prefetching IFU with a simple AXI4-Lite instruction memory model.
module tb_ysyx_23060061_ifu_prefetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        iduReady = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  logic        slave_arready = 1'b1;
  int          slave_rdelay = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;

  logic        s_rvalid;
  logic        s_pending;
  logic [31:0] s_addr;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  int          s_cnt;

  logic [31:0] ar_log[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_inst[$];
  logic [31:0] acc_fault[$];

  int checks = 0;
  int errors = 0;

  ysyx_23060061_ifu_prefetch_if axi ();

  ysyx_23060061_ifu_prefetch #(
    .RESET_PC   (32'h8000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .iduReady       (iduReady),
    .axi            (axi)
  );

  always #5 clk = ~clk;

  assign axi.arready = slave_arready;
  assign axi.rvalid  = s_rvalid;
  assign axi.rdata   = s_rdata;
  assign axi.rresp   = s_rresp;

  function automatic logic [1:0] respFor(input logic [31:0] a);
    return (err_en && a == err_addr) ? 2'b10 : 2'b00;
  endfunction

  // Memory model: data = addr ^ KEY, optional error address, configurable read latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rvalid  <= 1'b0;
      s_pending <= 1'b0;
      s_cnt     <= 0;
      s_addr    <= '0;
      s_rdata   <= '0;
      s_rresp   <= '0;
    end else begin
      if (s_rvalid && axi.rready) s_rvalid <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        if (slave_rdelay == 0) begin
          s_rvalid <= 1'b1;
          s_rdata  <= axi.araddr ^ KEY;
          s_rresp  <= respFor(axi.araddr);
        end else begin
          s_pending <= 1'b1;
          s_addr    <= axi.araddr;
          s_cnt     <= slave_rdelay - 1;
        end
      end else if (s_pending) begin
        if (s_cnt == 0) begin
          s_pending <= 1'b0;
          s_rvalid  <= 1'b1;
          s_rdata   <= s_addr ^ KEY;
          s_rresp   <= respFor(s_addr);
        end else begin
          s_cnt <= s_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && axi.arvalid && axi.arready) ar_log.push_back(axi.araddr);
    if (!rst && inst_valid && iduReady && !redirect_valid) begin
      acc_pc.push_back(inst_pc);
      acc_inst.push_back(inst);
      acc_fault.push_back({31'b0, inst_fault});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] qAt(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic applyReset();
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iduReady       = 1'b0;
    slave_arready  = 1'b1;
    slave_rdelay   = 0;
    err_en         = 1'b0;
    err_addr       = '0;
    ar_log.delete();
    acc_pc.delete();
    acc_inst.delete();
    acc_fault.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] pc, input logic ready);
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = pc;
    iduReady       = ready;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic waitAr(input int n, input string tag);
    for (int i = 0; i < 300 && ar_log.size() < n; i++) @(negedge clk);
    checkOutput(tag, 32'(ar_log.size()), 32'(n));
  endtask

  task automatic waitAcc(input int n, input string tag);
    for (int i = 0; i < 300 && acc_pc.size() < n; i++) @(negedge clk);
    checkOutput(tag, 32'(acc_pc.size()), 32'(n));
  endtask

  initial begin
    int ar_n;
    int stale;

    $display("[TB] reset and sequential fetch");
    applyReset();
    checkOutput("rst_arvalid", 32'(axi.arvalid), 32'd0);
    checkOutput("rst_rready", 32'(axi.rready), 32'd0);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_araddr", axi.araddr, 32'h8000_0000);
    iduReady = 1'b1;
    rst      = 1'b0;
    waitAcc(3, "seq_acc_count");
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("seq_araddr%0d", i), qAt(ar_log, i), 32'h8000_0000 + 32'(4 * i));
      checkOutput($sformatf("seq_pc%0d", i), qAt(acc_pc, i), 32'h8000_0000 + 32'(4 * i));
      checkOutput($sformatf("seq_inst%0d", i), qAt(acc_inst, i), (32'h8000_0000 + 32'(4 * i)) ^ KEY);
      checkOutput($sformatf("seq_fault%0d", i), qAt(acc_fault, i), 32'd0);
    end
    for (int i = 0; i < 10 && !axi.arvalid; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("async_rst_arvalid", 32'(axi.arvalid), 32'd0);
    checkOutput("async_rst_araddr", axi.araddr, 32'h8000_0000);

    $display("[TB] backpressure");
    applyReset();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("bp_ar_count", 32'(ar_log.size()), 32'd4);
    checkOutput("bp_arvalid", 32'(axi.arvalid), 32'd0);
    checkOutput("bp_head_valid", 32'(inst_valid), 32'd1);
    checkOutput("bp_head_pc", inst_pc, 32'h8000_0000);
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitAr(5, "bp_resume_count");
    checkOutput("bp_resume_addr", qAt(ar_log, 4), 32'h8000_0010);

    $display("[TB] redirect latency from a full idle queue");
    applyReset();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(1'b1, 32'h8000_0300, 1'b0);
    checkOutput("lat_c1_arvalid", 32'(axi.arvalid), 32'd1);
    checkOutput("lat_c1_araddr", axi.araddr, 32'h8000_0300);
    checkOutput("lat_c1_flushed", 32'(inst_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_c2_rready", 32'(axi.rready), 32'd1);
    checkOutput("lat_c2_arvalid", 32'(axi.arvalid), 32'd0);
    @(negedge clk);
    checkOutput("lat_c3_valid", 32'(inst_valid), 32'd1);
    checkOutput("lat_c3_pc", inst_pc, 32'h8000_0300);
    checkOutput("lat_c3_inst", inst, 32'h8000_0300 ^ KEY);

    $display("[TB] squash in WAIT_DATA");
    applyReset();
    iduReady     = 1'b1;
    slave_rdelay = 3;
    rst          = 1'b0;
    for (int i = 0; i < 50 && !axi.rready; i++) @(negedge clk);
    checkOutput("sq_reach_wait", 32'(axi.rready), 32'd1);
    acc_pc.delete();
    acc_inst.delete();
    acc_fault.delete();
    ar_n = ar_log.size();
    applyStimulus(1'b1, 32'h8000_0100, 1'b1);
    waitAr(ar_n + 1, "sq_ar_count");
    checkOutput("sq_next_addr", qAt(ar_log, ar_n), 32'h8000_0100);
    waitAcc(2, "sq_acc_count");
    checkOutput("sq_pc0", qAt(acc_pc, 0), 32'h8000_0100);
    checkOutput("sq_pc1", qAt(acc_pc, 1), 32'h8000_0104);
    stale = 0;
    foreach (acc_pc[i]) if (acc_pc[i] < 32'h8000_0100) stale++;
    checkOutput("sq_stale_entries", 32'(stale), 32'd0);

    $display("[TB] redirect in SEND_ADDR with stalled arready");
    applyReset();
    iduReady      = 1'b1;
    slave_arready = 1'b0;
    rst           = 1'b0;
    for (int i = 0; i < 20 && !axi.arvalid; i++) @(negedge clk);
    acc_pc.delete();
    acc_inst.delete();
    acc_fault.delete();
    applyStimulus(1'b1, 32'h8000_0200, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("sa_hold_arvalid%0d", i), 32'(axi.arvalid), 32'd1);
      checkOutput($sformatf("sa_hold_araddr%0d", i), axi.araddr, 32'h8000_0000);
      @(negedge clk);
    end
    slave_arready = 1'b1;
    waitAr(3, "sa_ar_count");
    checkOutput("sa_ar0", qAt(ar_log, 0), 32'h8000_0000);
    checkOutput("sa_ar1", qAt(ar_log, 1), 32'h8000_0200);
    checkOutput("sa_ar2", qAt(ar_log, 2), 32'h8000_0204);
    waitAcc(1, "sa_acc_count");
    checkOutput("sa_first_pc", qAt(acc_pc, 0), 32'h8000_0200);

    $display("[TB] bus error");
    applyReset();
    iduReady = 1'b1;
    err_en   = 1'b1;
    err_addr = 32'h8000_0008;
    rst      = 1'b0;
    waitAcc(3, "be_acc_count");
    checkOutput("be_ok_inst", qAt(acc_inst, 1), 32'h8000_0004 ^ KEY);
    checkOutput("be_pc", qAt(acc_pc, 2), 32'h8000_0008);
    checkOutput("be_inst", qAt(acc_inst, 2), 32'h0);
    checkOutput("be_fault", qAt(acc_fault, 2), 32'd1);
    repeat (10) @(negedge clk);
    checkOutput("be_halt_ar_count", 32'(ar_log.size()), 32'd3);
    checkOutput("be_halt_arvalid", 32'(axi.arvalid), 32'd0);
    err_en = 1'b0;
    applyStimulus(1'b1, 32'h8000_0000, 1'b1);
    waitAr(4, "be_resume_count");
    checkOutput("be_resume_addr", qAt(ar_log, 3), 32'h8000_0000);

    $display("[TB] misaligned redirect");
    applyReset();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    acc_pc.delete();
    acc_inst.delete();
    acc_fault.delete();
    applyStimulus(1'b1, 32'h8000_0002, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("mis_ar_count", 32'(ar_log.size()), 32'd4);
    checkOutput("mis_acc_count", 32'(acc_pc.size()), 32'd1);
    checkOutput("mis_pc", qAt(acc_pc, 0), 32'h8000_0002);
    checkOutput("mis_inst", qAt(acc_inst, 0), 32'h0);
    checkOutput("mis_fault", qAt(acc_fault, 0), 32'd1);
    checkOutput("mis_arvalid", 32'(axi.arvalid), 32'd0);
    checkOutput("mis_queue_empty", 32'(inst_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
